// File: rtl/axil_spi_regs.sv
// AXI-Lite register bank fronting the SPI master core: CTRL, STATUS, TXDATA, RXDATA.
// Write and read channels run independent two-state FSMs; RX capture tracks full/overrun.
module axil_spi_regs #(
    parameter int AXI_DATA_WIDTH = 32,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int SPI_DATA_WIDTH = 8
) (
    input  logic                          aclk,
    input  logic                          areset,
    input  logic [AXI_ADDR_WIDTH-1:0]     s_axil_awaddr,
    input  logic                          s_axil_awvalid,
    output logic                          s_axil_awready,
    input  logic [AXI_DATA_WIDTH-1:0]     s_axil_wdata,
    input  logic [AXI_DATA_WIDTH/8-1:0]   s_axil_wstrb,
    input  logic                          s_axil_wvalid,
    output logic                          s_axil_wready,
    output logic [1:0]                    s_axil_bresp,
    output logic                          s_axil_bvalid,
    input  logic                          s_axil_bready,
    input  logic [AXI_ADDR_WIDTH-1:0]     s_axil_araddr,
    input  logic                          s_axil_arvalid,
    output logic                          s_axil_arready,
    output logic [AXI_DATA_WIDTH-1:0]     s_axil_rdata,
    output logic [1:0]                    s_axil_rresp,
    output logic                          s_axil_rvalid,
    input  logic                          s_axil_rready,
    output logic                          spi_enable,
    output logic                          spi_cpol,
    output logic                          spi_cpha,
    output logic [7:0]                    spi_clkdiv,
    output logic [SPI_DATA_WIDTH-1:0]     tx_data,
    output logic                          tx_valid,
    input  logic                          tx_ready,
    input  logic [SPI_DATA_WIDTH-1:0]     rx_data,
    input  logic                          rx_valid_i,
    input  logic                          spi_busy,
    output logic                          wr_state_dbg,
    output logic                          rd_state_dbg
);
    localparam int DW  = AXI_DATA_WIDTH;
    localparam int AW  = AXI_ADDR_WIDTH;
    localparam int SDW = SPI_DATA_WIDTH;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic { W_IDLE = 1'b0, W_RESP = 1'b1 } w_state_e;
    typedef enum logic { R_IDLE = 1'b0, R_DATA = 1'b1 } r_state_e;

    w_state_e          w_state_q, w_state_d;
    r_state_e          r_state_q, r_state_d;
    logic              aw_held_q, aw_held_d, w_held_q, w_held_d;
    logic [AW-1:0]     aw_addr_q, aw_addr_d;
    logic [DW-1:0]     w_data_q, w_data_d;
    logic [DW/8-1:0]   w_strb_q, w_strb_d;
    logic [1:0]        bresp_q, bresp_d, rresp_q, rresp_d;
    logic [DW-1:0]     rdata_q, rdata_d;
    logic              rd_rx_q, rd_rx_d;
    logic              en_q, en_d, cpol_q, cpol_d, cpha_q, cpha_d;
    logic [7:0]        clkdiv_q, clkdiv_d;
    logic              tx_valid_q, tx_valid_d;
    logic [SDW-1:0]    tx_data_q, tx_data_d;
    logic              rx_full_q, rx_full_d, overrun_q, overrun_d;
    logic [SDW-1:0]    rx_data_q, rx_data_d;

    logic              aw_fire, w_fire, aw_have, w_have, tx_fire;
    logic [AW-1:0]     wa;
    logic [DW-1:0]     wd, rd_word;
    logic [DW/8-1:0]   ws;
    logic              status_w1c, rx_clear, tx_load, overrun_set;
    logic              unused_ok;

    // Every channel transfers on the cycle where its valid and ready are both 1 at the
    // rising edge; a source holds valid and payload stable until that transfer happens.
    assign s_axil_awready = (w_state_q == W_IDLE) && !aw_held_q;
    assign s_axil_wready  = (w_state_q == W_IDLE) && !w_held_q;
    assign s_axil_bvalid  = (w_state_q == W_RESP);
    assign s_axil_bresp   = bresp_q;
    assign s_axil_arready = (r_state_q == R_IDLE);
    assign s_axil_rvalid  = (r_state_q == R_DATA);
    assign s_axil_rdata   = rdata_q;
    assign s_axil_rresp   = rresp_q;

    assign aw_fire = s_axil_awvalid && s_axil_awready;
    assign w_fire  = s_axil_wvalid && s_axil_wready;
    assign aw_have = aw_held_q || aw_fire;
    assign w_have  = w_held_q || w_fire;
    assign wa      = aw_held_q ? aw_addr_q : s_axil_awaddr;
    assign wd      = w_held_q ? w_data_q : s_axil_wdata;
    assign ws      = w_held_q ? w_strb_q : s_axil_wstrb;
    assign tx_fire = tx_valid_q && tx_ready;

    always_comb begin
        w_state_d   = w_state_q;
        r_state_d   = r_state_q;
        aw_held_d   = aw_held_q;
        w_held_d    = w_held_q;
        aw_addr_d   = aw_addr_q;
        w_data_d    = w_data_q;
        w_strb_d    = w_strb_q;
        bresp_d     = bresp_q;
        rresp_d     = rresp_q;
        rdata_d     = rdata_q;
        rd_rx_d     = rd_rx_q;
        en_d        = en_q;
        cpol_d      = cpol_q;
        cpha_d      = cpha_q;
        clkdiv_d    = clkdiv_q;
        tx_data_d   = tx_data_q;
        rx_data_d   = rx_data_q;
        rx_full_d   = rx_full_q;
        status_w1c  = 1'b0;
        rx_clear    = 1'b0;
        tx_load     = 1'b0;
        overrun_set = 1'b0;
        rd_word     = '0;

        case (w_state_q)
            W_IDLE: begin
                if (aw_fire) begin
                    aw_held_d = 1'b1;
                    aw_addr_d = s_axil_awaddr;
                end
                if (w_fire) begin
                    w_held_d = 1'b1;
                    w_data_d = s_axil_wdata;
                    w_strb_d = s_axil_wstrb;
                end
                // The write commits on the edge where the second half arrives.
                if (aw_have && w_have) begin
                    aw_held_d = 1'b0;
                    w_held_d  = 1'b0;
                    w_state_d = W_RESP;
                    bresp_d   = RESP_OKAY;
                    if (|wa[AW-1:4]) begin
                        bresp_d = RESP_SLVERR;
                    end else begin
                        case (wa[3:2])
                            2'd0: begin
                                if (ws[0]) begin
                                    en_d   = wd[0];
                                    cpol_d = wd[1];
                                    cpha_d = wd[2];
                                end
                                if (ws[1]) clkdiv_d = wd[15:8];
                            end
                            2'd1: status_w1c = ws[0] && wd[3];
                            2'd2: begin
                                if (tx_valid_q && !tx_ready) bresp_d = RESP_SLVERR;
                                else tx_load = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
            end
            W_RESP: if (s_axil_bready) w_state_d = W_IDLE;
            default: w_state_d = W_IDLE;
        endcase

        case (r_state_q)
            R_IDLE: begin
                if (s_axil_arvalid) begin
                    r_state_d = R_DATA;
                    rresp_d   = RESP_OKAY;
                    rd_rx_d   = 1'b0;
                    if (|s_axil_araddr[AW-1:4]) begin
                        rresp_d = RESP_SLVERR;
                    end else begin
                        case (s_axil_araddr[3:2])
                            2'd0: begin
                                rd_word[0]    = en_q;
                                rd_word[1]    = cpol_q;
                                rd_word[2]    = cpha_q;
                                rd_word[15:8] = clkdiv_q;
                            end
                            2'd1: rd_word[3:0] = {overrun_q, spi_busy, rx_full_q, tx_valid_q};
                            2'd3: begin
                                rd_word[SDW-1:0] = rx_data_q;
                                rd_rx_d          = 1'b1;
                            end
                            default: ;
                        endcase
                    end
                    rdata_d = rd_word;
                end
            end
            R_DATA: begin
                if (s_axil_rready) begin
                    r_state_d = R_IDLE;
                    rx_clear  = rd_rx_q;
                end
            end
            default: r_state_d = R_IDLE;
        endcase

        tx_valid_d = tx_valid_q && !tx_fire;
        if (tx_load) begin
            tx_valid_d = 1'b1;
            tx_data_d  = wd[SDW-1:0];
        end

        // A fresh RX word always wins over a clearing RXDATA read in the same cycle.
        if (rx_valid_i) begin
            rx_data_d   = rx_data;
            rx_full_d   = 1'b1;
            overrun_set = rx_full_q && !rx_clear;
        end else if (rx_clear) begin
            rx_full_d = 1'b0;
        end
        overrun_d = overrun_set || (overrun_q && !status_w1c);
    end

    always_ff @(posedge aclk) begin
        if (areset) begin
            w_state_q  <= W_IDLE;
            r_state_q  <= R_IDLE;
            aw_held_q  <= 1'b0;
            w_held_q   <= 1'b0;
            aw_addr_q  <= '0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            bresp_q    <= RESP_OKAY;
            rresp_q    <= RESP_OKAY;
            rdata_q    <= '0;
            rd_rx_q    <= 1'b0;
            en_q       <= 1'b0;
            cpol_q     <= 1'b0;
            cpha_q     <= 1'b0;
            clkdiv_q   <= '0;
            tx_valid_q <= 1'b0;
            tx_data_q  <= '0;
            rx_data_q  <= '0;
            rx_full_q  <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            w_state_q  <= w_state_d;
            r_state_q  <= r_state_d;
            aw_held_q  <= aw_held_d;
            w_held_q   <= w_held_d;
            aw_addr_q  <= aw_addr_d;
            w_data_q   <= w_data_d;
            w_strb_q   <= w_strb_d;
            bresp_q    <= bresp_d;
            rresp_q    <= rresp_d;
            rdata_q    <= rdata_d;
            rd_rx_q    <= rd_rx_d;
            en_q       <= en_d;
            cpol_q     <= cpol_d;
            cpha_q     <= cpha_d;
            clkdiv_q   <= clkdiv_d;
            tx_valid_q <= tx_valid_d;
            tx_data_q  <= tx_data_d;
            rx_data_q  <= rx_data_d;
            rx_full_q  <= rx_full_d;
            overrun_q  <= overrun_d;
        end
    end

    assign spi_enable   = en_q;
    assign spi_cpol     = cpol_q;
    assign spi_cpha     = cpha_q;
    assign spi_clkdiv   = clkdiv_q;
    assign tx_data      = tx_data_q;
    assign tx_valid     = tx_valid_q;
    assign wr_state_dbg = (w_state_q == W_RESP);
    assign rd_state_dbg = (r_state_q == R_DATA);

    // Byte-lane address bits and unmapped data/strobe bits carry no meaning here.
    assign unused_ok = ^{wa[1:0], s_axil_araddr[1:0], wd, ws};
endmodule

// File: tb/tb_axil_spi_regs.sv
// Directed bench for axil_spi_regs: register access, TX/RX handshakes, decode errors,
// response back-pressure and reset abort.
module tb_axil_spi_regs;
    logic        clk;
    logic        areset;
    logic [31:0] awaddr, wdata, araddr, rdata;
    logic [3:0]  wstrb;
    logic        awvalid, awready, wvalid, wready, bvalid, bready;
    logic        arvalid, arready, rvalid, rready;
    logic [1:0]  bresp, rresp;
    logic        spi_enable, spi_cpol, spi_cpha, tx_valid, tx_ready, rx_valid_i, spi_busy;
    logic [7:0]  spi_clkdiv, tx_data, rx_data;
    logic        wr_state_dbg, rd_state_dbg;

    int pass_cnt = 0;
    int total_cnt = 0;
    logic [1:0]  resp;
    logic [31:0] data;

    axil_spi_regs dut (
        .aclk(clk), .areset(areset),
        .s_axil_awaddr(awaddr), .s_axil_awvalid(awvalid), .s_axil_awready(awready),
        .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid), .s_axil_wready(wready),
        .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
        .s_axil_araddr(araddr), .s_axil_arvalid(arvalid), .s_axil_arready(arready),
        .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid), .s_axil_rready(rready),
        .spi_enable(spi_enable), .spi_cpol(spi_cpol), .spi_cpha(spi_cpha), .spi_clkdiv(spi_clkdiv),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid_i(rx_valid_i), .spi_busy(spi_busy),
        .wr_state_dbg(wr_state_dbg), .rd_state_dbg(rd_state_dbg)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before 200us");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called at posedge+1; returns at posedge+1 after the B handshake edge.
    task automatic axi_write(input logic [31:0] addr, input logic [31:0] d,
                             input logic [3:0] strb, output logic [1:0] r);
        int  n, m;
        logic aw_hs, w_hs;
        awaddr = addr; wdata = d; wstrb = strb;
        awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
        n = 0;
        while ((awvalid || wvalid) && n < 20) begin
            #1;
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            step();
            if (aw_hs) awvalid = 1'b0;
            if (w_hs) wvalid = 1'b0;
            n++;
        end
        m = 0;
        while (!bvalid && m < 20) begin
            step();
            m++;
        end
        r = bresp;
        step();
        bready = 1'b0;
        check("wr_timeout", 32'(n >= 20 || m >= 20), 32'd0);
    endtask

    task automatic axi_read(input logic [31:0] addr, output logic [31:0] d, output logic [1:0] r);
        int n, m;
        araddr = addr; arvalid = 1'b1; rready = 1'b1;
        n = 0;
        #1;
        while (!arready && n < 20) begin
            @(posedge clk);
            #2;
            n++;
        end
        step();
        arvalid = 1'b0;
        m = 0;
        while (!rvalid && m < 20) begin
            step();
            m++;
        end
        d = rdata;
        r = rresp;
        step();
        rready = 1'b0;
        check("rd_timeout", 32'(n >= 20 || m >= 20), 32'd0);
    endtask

    task automatic rx_strobe(input logic [7:0] d);
        rx_data = d;
        rx_valid_i = 1'b1;
        step();
        rx_valid_i = 1'b0;
    endtask

    initial begin
        areset = 1'b1;
        awaddr = '0; wdata = '0; wstrb = '0; awvalid = 1'b0; wvalid = 1'b0; bready = 1'b0;
        araddr = '0; arvalid = 1'b0; rready = 1'b0;
        tx_ready = 1'b0; rx_data = '0; rx_valid_i = 1'b0; spi_busy = 1'b0;
        repeat (3) step();
        areset = 1'b0;
        step();

        // Reset state
        check("rst_awready", 32'(awready), 32'd1);
        check("rst_wready", 32'(wready), 32'd1);
        check("rst_arready", 32'(arready), 32'd1);
        check("rst_bvalid", 32'(bvalid), 32'd0);
        check("rst_rvalid", 32'(rvalid), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_ctrl", {spi_clkdiv, 5'd0, spi_cpha, spi_cpol, spi_enable}, 16'h0000);
        check("rst_tx", {tx_valid, tx_data}, 9'h000);

        // T1: AW first, W three cycles later
        awaddr = 32'h0; awvalid = 1'b1;
        #1;
        check("t1_awready", 32'(awready), 32'd1);
        step();
        awvalid = 1'b0;
        check("t1_aw_held_awready", 32'(awready), 32'd0);
        check("t1_aw_held_wready", 32'(wready), 32'd1);
        step();
        check("t1_no_bvalid", 32'(bvalid), 32'd0);
        step();
        wdata = 32'h0000_2A07; wstrb = 4'hF; wvalid = 1'b1;
        step();
        wvalid = 1'b0;
        check("t1_bvalid", 32'(bvalid), 32'd1);
        check("t1_bresp", 32'(bresp), 32'd0);
        check("t1_wr_state", 32'(wr_state_dbg), 32'd1);
        check("t1_resp_wready", 32'(wready), 32'd0);
        check("t1_ctrl_out", {spi_clkdiv, 5'd0, spi_cpha, spi_cpol, spi_enable}, 16'h2A07);
        bready = 1'b1;
        step();
        bready = 1'b0;
        check("t1_bvalid_drop", 32'(bvalid), 32'd0);
        check("t1_ready_back", {awready, wready}, 2'b11);
        axi_read(32'h0, data, resp);
        check("t1_ctrl_read", data, 32'h0000_2A07);

        // T2: TX path
        axi_write(32'h8, 32'h0000_00A5, 4'hF, resp);
        check("t2_wr_resp", 32'(resp), 32'd0);
        check("t2_tx", {tx_valid, tx_data}, 9'h1A5);
        axi_read(32'h4, data, resp);
        check("t2_status", data, 32'h1);
        axi_read(32'h8, data, resp);
        check("t2_txdata_reads0", data, 32'h0);
        axi_write(32'h8, 32'h0000_005A, 4'hF, resp);
        check("t2_busy_slverr", 32'(resp), 32'd2);
        check("t2_data_kept", 32'(tx_data), 32'hA5);
        tx_ready = 1'b1;
        step();
        tx_ready = 1'b0;
        check("t2_tx_cleared", 32'(tx_valid), 32'd0);
        axi_write(32'h8, 32'h0000_0077, 4'hF, resp);
        check("t2_reload", {tx_valid, tx_data}, 9'h177);
        tx_ready = 1'b1;
        axi_write(32'h8, 32'h0000_0099, 4'hF, resp);
        tx_ready = 1'b0;
        check("t2_same_cycle_resp", 32'(resp), 32'd0);
        check("t2_same_cycle_data", 32'(tx_data), 32'h99);

        // T3: RX capture and clear-on-read
        rx_strobe(8'h3C);
        axi_read(32'h4, data, resp);
        check("t3_status_full", data, 32'h2);
        axi_read(32'hC, data, resp);
        check("t3_rxdata", data, 32'h3C);
        axi_read(32'h4, data, resp);
        check("t3_status_empty", data, 32'h0);
        spi_busy = 1'b1;
        axi_read(32'h4, data, resp);
        spi_busy = 1'b0;
        check("t3_status_busy", data, 32'h4);

        // T4: overrun and its W1C
        rx_strobe(8'h11);
        step();
        rx_strobe(8'h22);
        axi_read(32'h4, data, resp);
        check("t4_status_ovr", data, 32'hA);
        axi_read(32'hC, data, resp);
        check("t4_rx_newest", data, 32'h22);
        axi_write(32'h4, 32'h8, 4'hF, resp);
        check("t4_w1c_resp", 32'(resp), 32'd0);
        axi_read(32'h4, data, resp);
        check("t4_status_clear", data, 32'h0);

        // RX strobe on the same edge as the clearing RXDATA read
        rx_strobe(8'h55);
        araddr = 32'hC; arvalid = 1'b1; rready = 1'b0;
        step();
        arvalid = 1'b0;
        check("rx_race_rvalid", 32'(rvalid), 32'd1);
        check("rx_race_rdata", rdata, 32'h55);
        rready = 1'b1; rx_data = 8'h66; rx_valid_i = 1'b1;
        step();
        rready = 1'b0; rx_valid_i = 1'b0;
        axi_read(32'h4, data, resp);
        check("rx_race_status", data, 32'h2);
        axi_read(32'hC, data, resp);
        check("rx_race_word", data, 32'h66);

        // T5: decode errors and byte strobes
        axi_read(32'h10, data, resp);
        check("t5_rd_slverr", 32'(resp), 32'd2);
        check("t5_rd_zero", data, 32'h0);
        axi_write(32'h10, 32'h0, 4'hF, resp);
        check("t5_wr_slverr", 32'(resp), 32'd2);
        check("t5_ctrl_kept", {spi_clkdiv, 5'd0, spi_cpha, spi_cpol, spi_enable}, 16'h2A07);
        axi_write(32'hC, 32'hFF, 4'hF, resp);
        check("t5_ro_okay", 32'(resp), 32'd0);
        axi_write(32'h0, 32'h0000_FF00, 4'h1, resp);
        axi_read(32'h0, data, resp);
        check("t5_strobe_byte0", data, 32'h0000_2A00);

        // T6: held responses, then reset in mid-hold
        awaddr = 32'h0; wdata = 32'h0000_1101; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
        araddr = 32'h0; arvalid = 1'b1; bready = 1'b0; rready = 1'b0;
        step();
        awaddr = 32'h8; wdata = 32'hEE; araddr = 32'h4;
        for (int i = 0; i < 5; i++) begin
            #1;
            check("t6_b_hold", {bvalid, bresp}, 3'b100);
            check("t6_r_hold", {rvalid, rresp}, 3'b100);
            check("t6_rdata_hold", rdata, 32'h0000_2A00);
            check("t6_no_accept", {awready, wready, arready}, 3'b000);
            check("t6_state_dbg", {wr_state_dbg, rd_state_dbg}, 2'b11);
            step();
        end
        check("t6_ctrl_written", {spi_clkdiv, 5'd0, spi_cpha, spi_cpol, spi_enable}, 16'h1101);
        areset = 1'b1; awvalid = 1'b0; wvalid = 1'b0; arvalid = 1'b0;
        step();
        check("t6_rst_ready", {awready, wready, arready}, 3'b111);
        check("t6_rst_valid", {bvalid, rvalid, bresp, rresp}, 6'd0);
        check("t6_rst_rdata", rdata, 32'h0);
        check("t6_rst_ctrl", {spi_clkdiv, 5'd0, spi_cpha, spi_cpol, spi_enable}, 16'h0000);
        check("t6_rst_tx", {tx_valid, tx_data}, 9'h000);
        areset = 1'b0;
        step();
        axi_read(32'h4, data, resp);
        check("t6_post_status", data, 32'h0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
